// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, taken-branch squash and memory freeze.
// Optional perf counters are enabled by defining HAZ_PERF_CNT_EN; otherwise the counter outputs read 0.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_pcsrc_i,
  input  logic             dm_req_i,
  input  logic             dm_ready_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             id_ex_we_o,
  output logic             ex_mem_we_o,
  output logic             mem_wb_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                freeze;
  logic                branch;
  logic                load_use;

  always_comb begin
    freeze = ((state_q == ST_RUN)  && dm_req_i && !dm_ready_i) ||
             ((state_q == ST_WAIT) && !dm_ready_i) ||
             (state_q == ST_ERR);
    branch   = !freeze && mem_pcsrc_i;
    // A load writing r0 never creates a real dependency.
    load_use = !freeze && !mem_pcsrc_i && ex_memread_i && (ex_rt_i != 5'd0) &&
               ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  end

  // NOTE: every signal driven here gets its default first, so no path can leave it latched.
  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    id_ex_we_o     = 1'b1;
    ex_mem_we_o    = 1'b1;
    mem_wb_we_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (!rst_i) begin
      {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o} = 5'b00000;
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o}              = 3'b111;
    end else if (freeze) begin
      {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o} = 5'b00000;
    end else if (branch) begin
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o} = 3'b111;
    end else if (load_use) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign state_o = state_q;
  assign err_o   = rst_i && (state_q == ST_ERR);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (dm_req_i && !dm_ready_i) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        if (dm_ready_i) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (load_use && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch   && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (freeze   && (wait_cnt_q  != '1)) wait_cnt_q  <= wait_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign wait_cnt_o  = wait_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign wait_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle corner sequences and a random run
// against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int MAX_WAIT = 16;
  localparam int WAIT_W   = 5;
  localparam int CNT_W    = 16;

  localparam logic [7:0] O_NORM  = 8'b11111_000;
  localparam logic [7:0] O_LOAD  = 8'b00111_010;
  localparam logic [7:0] O_BR    = 8'b11111_111;
  localparam logic [7:0] O_FRZ   = 8'b00000_000;
  localparam logic [7:0] O_RST   = 8'b00000_111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, mem_pcsrc = 1'b0, dm_req = 1'b0, dm_ready = 1'b0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: memory-wait bookkeeping and event tallies.
  bit m_in_wait = 0;
  bit m_err = 0;
  int m_waited = 0;
  int m_stall = 0, m_flush = 0, m_wcnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .mem_pcsrc_i(mem_pcsrc),
    .dm_req_i(dm_req), .dm_ready_i(dm_ready),
    .pc_we_o(pc_we), .if_id_we_o(if_id_we), .id_ex_we_o(id_ex_we),
    .ex_mem_we_o(ex_mem_we), .mem_wb_we_o(mem_wb_we),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .ex_mem_flush_o(ex_mem_flush),
    .state_o(state), .err_o(err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .wait_cnt_o(wait_cnt)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ert;
    logic       pcsrc, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_freeze();
    return m_err || (m_in_wait ? !dm_ready : (dm_req && !dm_ready));
  endfunction

  function automatic bit m_hazard();
    return ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic logic [7:0] model_outs();
    if (!rst) return O_RST;
    if (m_freeze()) return O_FRZ;
    if (mem_pcsrc) return O_BR;
    if (m_hazard()) return O_LOAD;
    return O_NORM;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp(input int v);
`ifdef HAZ_PERF_CNT_EN
    return (v >= (1 << CNT_W) - 1) ? '1 : CNT_W'(v);
`else
    return (v < 0) ? '1 : '0;
`endif
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input string tag, input bit use_exp, input logic [7:0] exp,
                       input int exp_state);
    logic [7:0] outs;
    @(negedge clk);
    outs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, ex_mem_flush};
    check({tag, "_model"}, 32'(outs), 32'(model_outs()));
    if (use_exp) check({tag, "_outs"}, 32'(outs), 32'(exp));
    if (exp_state >= 0) check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_mstate"}, 32'(state), m_err ? 32'd2 : (m_in_wait ? 32'd1 : 32'd0));
    check({tag, "_err"}, 32'(err), 32'(rst && m_err));
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(cnt_exp(m_stall)));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(cnt_exp(m_flush)));
    check({tag, "_wait_cnt"}, 32'(wait_cnt), 32'(cnt_exp(m_wcnt)));
    @(posedge clk);
    if (!rst) begin
      m_in_wait = 0; m_err = 0; m_waited = 0;
      m_stall = 0; m_flush = 0; m_wcnt = 0;
    end else begin
      if (m_freeze()) m_wcnt++;
      else if (mem_pcsrc) m_flush++;
      else if (m_hazard()) m_stall++;
      if (!m_err) begin
        if (m_in_wait) begin
          if (dm_ready) m_in_wait = 0;
          else begin
            m_waited++;
            if (m_waited == MAX_WAIT) begin m_err = 1; m_in_wait = 0; end
          end
        end else if (dm_req && !dm_ready) begin
          m_in_wait = 1;
          m_waited = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
    mem_pcsrc = 0; dm_req = 0; dm_ready = 0;
  endtask

  initial begin
    vecs[0] = '{rs:2,  rt:0,  uses_rt:0, memread:1, ert:2,  pcsrc:0, req:0, rdy:0, exp:O_LOAD};
    vecs[1] = '{rs:0,  rt:0,  uses_rt:0, memread:0, ert:0,  pcsrc:0, req:0, rdy:0, exp:O_NORM};
    vecs[2] = '{rs:0,  rt:0,  uses_rt:1, memread:1, ert:0,  pcsrc:0, req:0, rdy:0, exp:O_NORM};
    vecs[3] = '{rs:2,  rt:0,  uses_rt:0, memread:1, ert:2,  pcsrc:1, req:0, rdy:0, exp:O_BR};
    vecs[4] = '{rs:3,  rt:5,  uses_rt:1, memread:1, ert:5,  pcsrc:0, req:0, rdy:0, exp:O_LOAD};
    vecs[5] = '{rs:3,  rt:5,  uses_rt:0, memread:1, ert:5,  pcsrc:0, req:0, rdy:0, exp:O_NORM};
    vecs[6] = '{rs:2,  rt:2,  uses_rt:1, memread:0, ert:2,  pcsrc:0, req:0, rdy:0, exp:O_NORM};
    vecs[7] = '{rs:7,  rt:1,  uses_rt:0, memread:1, ert:7,  pcsrc:0, req:1, rdy:1, exp:O_LOAD};
    vecs[8] = '{rs:30, rt:31, uses_rt:1, memread:1, ert:31, pcsrc:0, req:0, rdy:0, exp:O_LOAD};
    vecs[9] = '{rs:0,  rt:0,  uses_rt:0, memread:0, ert:0,  pcsrc:1, req:1, rdy:1, exp:O_BR};

    idle_inputs();
    rst = 0;
    @(posedge clk); #1;
    cycle("reset", 1, O_RST, 0);
    rst = 1;

    foreach (vecs[i]) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
      ex_memread = vecs[i].memread; ex_rt = vecs[i].ert; mem_pcsrc = vecs[i].pcsrc;
      dm_req = vecs[i].req; dm_ready = vecs[i].rdy;
      cycle($sformatf("vec%0d", i), 1, vecs[i].exp, 0);
    end

    // Load-use lasts one cycle once the load leaves EX.
    idle_inputs();
    id_rs = 2; ex_rt = 2; ex_memread = 1;
    cycle("lu_stall", 1, O_LOAD, 0);
    ex_memread = 0;
    cycle("lu_release", 1, O_NORM, 0);

    // Three-cycle memory freeze, with a branch held in MEM across it.
    idle_inputs();
    dm_req = 1; mem_pcsrc = 1;
    cycle("frz0", 1, O_FRZ, 0);
    cycle("frz1", 1, O_FRZ, 1);
    cycle("frz2", 1, O_FRZ, 1);
    dm_ready = 1;
    cycle("frz_done", 1, O_BR, 1);
    idle_inputs();
    cycle("frz_after", 1, O_NORM, 0);

    // Timeout: RUN entry plus MAX_WAIT wait cycles, then sticky error.
    dm_req = 1;
    cycle("to_entry", 1, O_FRZ, 0);
    for (int i = 0; i < MAX_WAIT; i++) cycle($sformatf("to_wait%0d", i), 1, O_FRZ, 1);
    cycle("to_err0", 1, O_FRZ, 2);
    dm_ready = 1; dm_req = 0;
    cycle("to_err1", 1, O_FRZ, 2);
    rst = 0;
    cycle("to_rst", 1, O_RST, 2);
    rst = 1;
    idle_inputs();
    cycle("to_clear", 1, O_NORM, 0);

    // Reset taken mid-wait while a branch is pending.
    dm_req = 1;
    cycle("rw_entry", 1, O_FRZ, 0);
    cycle("rw_wait", 1, O_FRZ, 1);
    mem_pcsrc = 1; rst = 0;
    cycle("rw_rst", 1, O_RST, 1);
    rst = 1; idle_inputs();
    cycle("rw_after", 1, O_NORM, 0);

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      ex_memread = 1'($urandom);
      mem_pcsrc  = ($urandom_range(0, 3) == 0);
      dm_req     = 1'($urandom);
      dm_ready   = ($urandom_range(0, 3) != 0);
      cycle("rand", 0, 8'h00, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
